// File: rtl/id_slot_alloc.sv
// Slot allocator for the AXI monitor ID tracking table: round-robin grant of free
// slots, release/reclaim with illegal-release detection, and lowest-index ID lookup.
module id_slot_alloc #(
   parameter  int IdCapacity = 16,
   parameter  int IdWidth    = 4,
   localparam int SlotIdxW   = $clog2(IdCapacity),
   localparam int CntW       = $clog2(IdCapacity + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alloc_valid_i,
   input  logic [IdWidth-1:0]    alloc_id_i,
   output logic                  alloc_ready_o,
   output logic [SlotIdxW-1:0]   alloc_idx_o,
   input  logic                  rel_valid_i,
   input  logic [SlotIdxW-1:0]   rel_idx_i,
   input  logic [IdWidth-1:0]    lookup_id_i,
   output logic                  lookup_hit_o,
   output logic [SlotIdxW-1:0]   lookup_idx_o,
   output logic [IdCapacity-1:0] free_o,
   output logic [CntW-1:0]       count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  err_o
);

   logic [IdCapacity-1:0] free_q, free_d;
   logic [IdWidth-1:0]    id_q [IdCapacity];
   logic [IdWidth-1:0]    id_d [IdCapacity];
   logic [SlotIdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  err_q, err_d;

   logic                  grant_found;
   logic [SlotIdxW-1:0]   grant_idx;
   logic                  alloc_fire;
   logic                  rel_in_range;
   logic                  rel_slot_free;
   logic                  rel_fire;
   logic                  full;

   assign full          = (count_q == CntW'(IdCapacity));
   assign alloc_ready_o = !full;
   assign alloc_idx_o   = grant_idx;
   assign alloc_fire    = alloc_valid_i && alloc_ready_o;

   // Out-of-range indices are treated as "already free" so they fall into the error path.
   assign rel_in_range  = (int'(rel_idx_i) < IdCapacity);
   assign rel_slot_free = rel_in_range ? free_q[rel_idx_i] : 1'b1;
   assign rel_fire      = rel_valid_i && !rel_slot_free;

   // Grant scan starts at the round-robin pointer and wraps explicitly, so
   // non-power-of-two capacities work; it only looks at registered state.
   always_comb begin
      int j;
      j           = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < IdCapacity; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= IdCapacity) j = j - IdCapacity;
         if (!grant_found && free_q[j]) begin
            grant_found = 1'b1;
            grant_idx   = SlotIdxW'(j);
         end
      end
   end

   // Descending scan so the lowest matching busy slot is the one left standing.
   always_comb begin
      lookup_hit_o = 1'b0;
      lookup_idx_o = '0;
      for (int i = IdCapacity - 1; i >= 0; i--) begin
         if (!free_q[i] && (id_q[i] == lookup_id_i)) begin
            lookup_hit_o = 1'b1;
            lookup_idx_o = SlotIdxW'(i);
         end
      end
   end

   always_comb begin
      free_d   = free_q;
      id_d     = id_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q;
      err_d    = rel_valid_i && rel_slot_free;
      if (alloc_fire) begin
         free_d[grant_idx] = 1'b0;
         id_d[grant_idx]   = alloc_id_i;
         rr_ptr_d          = (int'(grant_idx) == IdCapacity - 1) ? '0
                                                                  : grant_idx + SlotIdxW'(1);
      end
      if (rel_fire) free_d[rel_idx_i] = 1'b1;
      if (alloc_fire && !rel_fire)      count_d = count_q + CntW'(1);
      else if (!alloc_fire && rel_fire) count_d = count_q - CntW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         free_q   <= '1;
         rr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         for (int i = 0; i < IdCapacity; i++) id_q[i] <= '0;
      end else begin
         free_q   <= free_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         for (int i = 0; i < IdCapacity; i++) id_q[i] <= id_d[i];
      end
   end

   assign free_o  = free_q;
   assign count_o = count_q;
   assign full_o  = full;
   assign empty_o = (count_q == '0);
   assign err_o   = err_q;

endmodule

// File: tb/tb_id_slot_alloc.sv
// Directed bench for id_slot_alloc: a 16-slot instance for the main scenarios and a
// 12-slot instance for the out-of-range release case.
module tb_id_slot_alloc;

   logic        clk;
   logic        rst_n;

   logic        alloc_valid;
   logic [3:0]  alloc_id;
   logic        alloc_ready;
   logic [3:0]  alloc_idx;
   logic        rel_valid;
   logic [3:0]  rel_idx;
   logic [3:0]  lookup_id;
   logic        lookup_hit;
   logic [3:0]  lookup_idx;
   logic [15:0] free_v;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        err;

   logic        a12_valid;
   logic [3:0]  a12_id;
   logic        a12_ready;
   logic [3:0]  a12_idx;
   logic        r12_valid;
   logic [3:0]  r12_idx;
   logic [3:0]  l12_id;
   logic        l12_hit;
   logic [3:0]  l12_idx;
   logic [11:0] free12;
   logic [3:0]  count12;
   logic        full12;
   logic        empty12;
   logic        err12;

   int checks = 0;
   int errors = 0;

   logic [3:0] lk_ids [7] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5, 4'h6, 4'hA};

   id_slot_alloc #(.IdCapacity(16), .IdWidth(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_i(alloc_valid), .alloc_id_i(alloc_id),
      .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
      .rel_valid_i(rel_valid), .rel_idx_i(rel_idx),
      .lookup_id_i(lookup_id), .lookup_hit_o(lookup_hit), .lookup_idx_o(lookup_idx),
      .free_o(free_v), .count_o(count), .full_o(full), .empty_o(empty), .err_o(err)
   );

   id_slot_alloc #(.IdCapacity(12), .IdWidth(4)) dut12 (
      .clk_i(clk), .rst_ni(rst_n),
      .alloc_valid_i(a12_valid), .alloc_id_i(a12_id),
      .alloc_ready_o(a12_ready), .alloc_idx_o(a12_idx),
      .rel_valid_i(r12_valid), .rel_idx_i(r12_idx),
      .lookup_id_i(l12_id), .lookup_hit_o(l12_hit), .lookup_idx_o(l12_idx),
      .free_o(free12), .count_o(count12), .full_o(full12), .empty_o(empty12), .err_o(err12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      alloc_valid = 1'b0; alloc_id = '0; rel_valid = 1'b0; rel_idx = '0; lookup_id = '0;
      a12_valid = 1'b0; a12_id = '0; r12_valid = 1'b0; r12_idx = '0; l12_id = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic alloc_one(input logic [3:0] id, input logic [3:0] exp_idx, input string tag);
      alloc_valid = 1'b1;
      alloc_id    = id;
      chk(tag, {28'd0, alloc_idx}, {28'd0, exp_idx});
      step();
      alloc_valid = 1'b0;
   endtask

   task automatic release_one(input logic [3:0] idx);
      rel_valid = 1'b1;
      rel_idx   = idx;
      step();
      rel_valid = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      step();
      // Reset state, sampled while reset is still asserted
      chk("rst_free",  32'(free_v), 32'hFFFF);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_ready", 32'(alloc_ready), 32'd1);
      chk("rst_idx",   32'(alloc_idx), 32'd0);
      chk("rst_hit",   32'(lookup_hit), 32'd0);
      rst_n = 1'b1;

      // Fill all 16 slots with ID = slot index
      for (int i = 0; i < 16; i++) begin
         alloc_valid = 1'b1;
         alloc_id    = 4'(i);
         chk("fill_ready", 32'(alloc_ready), 32'd1);
         chk("fill_idx", 32'(alloc_idx), 32'(i));
         step();
      end
      alloc_valid = 1'b0;
      chk("full_flag",  32'(full), 32'd1);
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd16);
      chk("full_free",  32'(free_v), 32'h0000);
      chk("full_idx",   32'(alloc_idx), 32'd0);
      lookup_id = 4'd7;
      #1;
      chk("full_lk_hit", 32'(lookup_hit), 32'd1);
      chk("full_lk_idx", 32'(lookup_idx), 32'd7);

      // Request while full must not change anything
      alloc_valid = 1'b1;
      alloc_id    = 4'hF;
      step();
      alloc_valid = 1'b0;
      chk("noready_count", 32'(count), 32'd16);

      // Release 5 from full, then refill it
      release_one(4'd5);
      chk("rel5_free",  32'(free_v), 32'h0020);
      chk("rel5_ready", 32'(alloc_ready), 32'd1);
      chk("rel5_idx",   32'(alloc_idx), 32'd5);
      chk("rel5_count", 32'(count), 32'd15);
      alloc_one(4'h9, 4'd5, "refill5_idx");
      chk("refill5_free", 32'(free_v), 32'h0000);
      chk("refill5_full", 32'(full), 32'd1);

      // Round-robin fairness and wrap-around
      do_reset();
      alloc_one(4'h1, 4'd0, "rr_a0");
      alloc_one(4'h1, 4'd1, "rr_a1");
      alloc_one(4'h1, 4'd2, "rr_a2");
      release_one(4'd0);
      alloc_one(4'h1, 4'd3, "rr_not0");
      release_one(4'd1);
      release_one(4'd2);
      chk("rr_count1", 32'(count), 32'd1);
      for (int i = 0; i < 13; i++) begin
         alloc_valid = 1'b1;
         alloc_id    = 4'h2;
         chk("rr_wrap_idx", 32'(alloc_idx), (i < 12) ? 32'(i + 4) : 32'd0);
         step();
      end
      alloc_valid = 1'b0;
      chk("rr_count14", 32'(count), 32'd14);
      chk("rr_free",    32'(free_v), 32'h0006);

      // Simultaneous grant and legal release
      do_reset();
      alloc_one(4'h1, 4'd0, "sim_a0");
      alloc_one(4'h1, 4'd1, "sim_a1");
      alloc_valid = 1'b1;
      alloc_id    = 4'h3;
      rel_valid   = 1'b1;
      rel_idx     = 4'd0;
      chk("sim_grant", 32'(alloc_idx), 32'd2);
      step();
      alloc_valid = 1'b0;
      rel_valid   = 1'b0;
      chk("sim_count", 32'(count), 32'd2);
      chk("sim_free",  32'(free_v), 32'hFFF9);
      chk("sim_err",   32'(err), 32'd0);

      // Illegal release of an already-free slot
      release_one(4'd7);
      chk("ill7_err",   32'(err), 32'd1);
      chk("ill7_free",  32'(free_v), 32'hFFF9);
      chk("ill7_count", 32'(count), 32'd2);
      step();
      chk("ill7_pulse", 32'(err), 32'd0);

      // Out-of-range release on the 12-slot instance
      r12_valid = 1'b1;
      r12_idx   = 4'd15;
      step();
      r12_valid = 1'b0;
      chk("ill15_err",   32'(err12), 32'd1);
      chk("ill15_free",  32'(free12), 32'hFFF);
      chk("ill15_count", 32'(count12), 32'd0);
      step();
      chk("ill15_pulse", 32'(err12), 32'd0);

      // Lookup with duplicate IDs
      do_reset();
      for (int i = 0; i < 7; i++) alloc_one(lk_ids[i], 4'(i), "lk_alloc");
      lookup_id = 4'hA;
      #1;
      chk("lk_hit_a",   32'(lookup_hit), 32'd1);
      chk("lk_idx_a",   32'(lookup_idx), 32'd3);
      release_one(4'd3);
      chk("lk_idx_rel3", 32'(lookup_idx), 32'd6);
      release_one(4'd6);
      chk("lk_hit_rel6", 32'(lookup_hit), 32'd0);
      chk("lk_idx_rel6", 32'(lookup_idx), 32'd0);
      lookup_id = 4'h5;
      #1;
      chk("lk_idx_5", 32'(lookup_idx), 32'd4);

      // Reset mid-operation with a same-edge fire and release
      lookup_id   = 4'h1;
      alloc_valid = 1'b1;
      alloc_id    = 4'hC;
      rel_valid   = 1'b1;
      rel_idx     = 4'd0;
      rst_n       = 1'b0;
      step();
      alloc_valid = 1'b0;
      rel_valid   = 1'b0;
      rst_n       = 1'b1;
      chk("mid_free",  32'(free_v), 32'hFFFF);
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      chk("mid_ready", 32'(alloc_ready), 32'd1);
      chk("mid_idx",   32'(alloc_idx), 32'd0);
      chk("mid_hit",   32'(lookup_hit), 32'd0);
      chk("mid_err",   32'(err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_slot_alloc.md
# id_slot_alloc

Allocator/scheduler for the ID tracking table of the AXI monitor. Owns the per-slot busy/free state and hands free slots to new transactions with round-robin fairness. Reclaims slots when tracked transactions retire, and answers ID lookups so the monitor can find the slot belonging to a response. Its registered free vector is the table's free view consumed by the rest of the monitor.

## Interface
- IdCapacity, 16, number of tracking slots (≥2)
- IdWidth, 4, width of the tracked AXI ID
- SlotIdxW, $clog2(IdCapacity), slot index width (derived)
- CntW, $clog2(IdCapacity+1), occupancy counter width (derived)

- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, synchronous, active-low
- alloc_valid_i  in  1  request for a new slot
- alloc_id_i  in  IdWidth  AXI ID to store in the granted slot
- alloc_ready_o  out  1  a slot can be granted this cycle (= !full_o)
- alloc_idx_o  out  SlotIdxW  slot granted; valid while alloc_ready_o
- rel_valid_i  in  1  release request
- rel_idx_i  in  SlotIdxW  slot to release
- lookup_id_i  in  IdWidth  ID to search among busy slots
- lookup_hit_o  out  1  some busy slot holds lookup_id_i
- lookup_idx_o  out  SlotIdxW  lowest-index busy slot matching; 0 if no hit
- free_o  out  IdCapacity  registered free bitmap, bit i = slot i free
- count_o  out  CntW  number of busy slots
- full_o  out  1  count_o == IdCapacity
- empty_o  out  1  count_o == 0
- err_o  out  1  one-cycle pulse: illegal release

## Operation
- State: free_q[IdCapacity], id_q[IdCapacity][IdWidth], rr_ptr_q[SlotIdxW], count_q[CntW], err_q.
- Grant selection (combinational from free_q): first free slot scanning upward from rr_ptr_q, wrapping past IdCapacity-1 to 0. alloc_idx_o = that slot; 0 when full.
- Allocation handshake: fires when alloc_valid_i && alloc_ready_o. Next cycle: free_q[alloc_idx_o]=0, id_q[alloc_idx_o]=alloc_id_i, rr_ptr_q = (alloc_idx_o+1) mod IdCapacity. The pointer wraps explicitly for non-power-of-two IdCapacity.
- alloc_valid_i may be asserted without ready. A request does not need to be held; no state changes without a fire.
- Release: rel_valid_i with free_q[rel_idx_i]==0 sets free_q[rel_idx_i]=1 next cycle; id_q is kept.
- Illegal release, i.e. slot already free or rel_idx_i ≥ IdCapacity: no state change, err_o=1 next cycle for one cycle.
- Simultaneous alloc fire and legal release: both take effect. count_q is unchanged. A slot freed this cycle cannot be granted this cycle, because the grant uses free_q.
- Release of the slot being granted in the same cycle cannot occur: the granted slot is free, so that release is illegal and is handled as above.
- count_q: +1 on fire only, −1 on legal release only, unchanged when both or neither occur. It never over- or underflows by construction.
- Lookup: pure combinational over id_q and ~free_q. Free slots never hit. Duplicate IDs are allowed; the lowest index wins.
- free_o = free_q, count_o = count_q, full_o/empty_o derived from count_q, err_o = err_q.

## Timing
- Reset (rst_ni low at a clk_i edge): free_o all ones, count_o=0, empty_o=1, full_o=0, err_o=0, rr_ptr_q=0, id_q=0.
- During and after reset: alloc_ready_o=1, alloc_idx_o=0, lookup_hit_o=0.
- Reset asserted mid-operation discards all busy slots at that edge, including a same-edge fire and release.
- alloc_ready_o and alloc_idx_o depend only on registered state. There is no combinational path from alloc_valid_i, rel_*_i or lookup_id_i to alloc_ready_o or alloc_idx_o.
- Lookup latency 0 cycles. Alloc/release visible on free_o, count_o and lookup one cycle after the request edge.
- Full: after the IdCapacity-th fire, alloc_ready_o=0 from the next cycle. A legal release while full restores alloc_ready_o one cycle later.
- Back-to-back fires every cycle are supported. Throughput is 1 grant/cycle and 1 release/cycle.

## Test plan
- Reset, then alloc_valid_i held with IDs 0..15 (IdCapacity=16) → grants idx 0,1,…,15 on consecutive cycles, then full_o=1 and alloc_ready_o=0; count_o=16.
- From full, release idx 5 → next cycle free_o=16'h0020 and alloc_ready_o=1, alloc_idx_o=5. rr_ptr_q=0 so the scan wraps to slot 5; fire re-fills slot 5.
- Round-robin: alloc 0,1,2, release 0, alloc → grant 3, not 0. Then release 1,2 and alloc 13 times → grants 4..15 then 0, demonstrating wrap-around.
- Same-cycle fire (grant 2) and legal release of slot 0 with count 2 → count_o stays 2, free_o bit0=1, bit2=0.
- Release of already-free slot 7 → err_o one-cycle pulse, free_o and count_o unchanged. Repeat with rel_idx_i=15 when IdCapacity=12 → same.
- Store ID 4'hA in slots 3 and 6 → lookup_id_i=A gives hit=1, idx=3. Release 3 → idx=6. Release 6 → hit=0, idx=0.
- Reset asserted mid-operation with slots busy → all outputs return to reset values the next cycle.
